cordic_sweep_master: RTL and testbench

Bus initiator that drives the memory-mapped CORDIC rotation peripheral through its native register interface. It generates an arithmetic angle sweep and writes each angle to the ANGLE register. It then waits for the peripheral's done pulse, reads COS and SIN, and pushes each result into a small output FIFO with a valid/ready handshake. It sits between a host or DSP consumer and the CORDIC peripheral, so the consumer can obtain sin/cos tables without running a software polling loop.

---
 rtl/cordic_sweep_master_if.sv | 31 +++
 rtl/cordic_sweep_master.sv | 210 +++++++++++++++++++++
 tb/tb_cordic_sweep_master.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sweep_master_if.sv
// Bus and result-stream bundle between the sweep master and its
// CORDIC peripheral / result consumer.
interface cordic_sweep_master_if #(
    parameter int CNT_W = 16
);
    logic             bus_write;
    logic             bus_read;
    logic [5:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             done;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_cos;
    logic [15:0]      res_sin;
    logic [CNT_W-1:0] res_idx;

    modport master (
        output bus_write, bus_read, addr, wdata,
        input  rdata, done,
        output res_valid, res_cos, res_sin, res_idx,
        input  res_ready
    );

    modport slave (
        input  bus_write, bus_read, addr, wdata,
        output rdata, done,
        input  res_valid, res_cos, res_sin, res_idx,
        output res_ready
    );
endinterface

// File: rtl/cordic_sweep_master.sv
// Angle-sweep bus initiator for the CORDIC peripheral with result FIFO.
// Optional quadrant folding via `define CORDIC_QUAD_FOLD_EN.
module cordic_sweep_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      angle_start,
    input  logic [31:0]      angle_step,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             sweep_done,
    output logic             err_timeout,
    cordic_sweep_master_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int EW = 32 + CNT_W;

    localparam logic [5:0] A_ANGLE = 6'h04;
    localparam logic [5:0] A_COS   = 6'h08;
    localparam logic [5:0] A_SIN   = 6'h0C;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT, S_RD_COS, S_RD_SIN, S_PUSH, S_FINISH
    } state_e;

    state_e           state_q;
    logic [31:0]      angle_q, step_q, wdata_q;
    logic [CNT_W-1:0] cnt_q, idx_q;
    logic [WW-1:0]    wait_q;
    logic [15:0]      cos_q, sin_q;
    logic             busy_q, done_q, err_q, bw_q, br_q;
    logic [5:0]       addr_q;

    logic [31:0]      angle_d, wr_raw, wr_word;
    logic [CNT_W-1:0] idx_d;
    logic [WW-1:0]    wait_d;
    logic [15:0]      cos_fx, sin_fx;
    logic             unused_hi;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wp_q, rp_q;
    logic             full, empty, push, pop;
    logic [EW-1:0]    head;

    assign angle_d = angle_q + step_q;
    assign idx_d   = idx_q + CNT_W'(1);
    assign wait_d  = wait_q + WW'(1);
    assign wr_raw  = (state_q == S_IDLE) ? angle_start : angle_d;
    assign unused_hi = ^bus.rdata[31:16];

`ifdef CORDIC_QUAD_FOLD_EN
    logic fold_q;
    logic wr_fold;

    function automatic logic [15:0] neg_sat(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
    endfunction

    // Quadrants II/III map to IV/I by a 180 deg rotation, which negates both outputs
    assign wr_fold = wr_raw[31] ^ wr_raw[30];
    assign wr_word = wr_fold ? (wr_raw ^ 32'h8000_0000) : wr_raw;
    assign cos_fx  = fold_q ? neg_sat(cos_q) : cos_q;
    assign sin_fx  = fold_q ? neg_sat(sin_q) : sin_q;
`else
    assign wr_word = wr_raw;
    assign cos_fx  = cos_q;
    assign sin_fx  = sin_q;
`endif

    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty = (wp_q == rp_q);
    assign push  = (state_q == S_PUSH) && !full;
    assign pop   = !empty && bus.res_ready;
    assign head  = mem[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q[AW-1:0]] <= {cos_fx, sin_fx, idx_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + (AW+1)'(1);
            if (pop)  rp_q <= rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            angle_q <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bw_q    <= 1'b0;
            br_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef CORDIC_QUAD_FOLD_EN
            fold_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && count != '0) begin
                        angle_q <= angle_start;
                        step_q  <= angle_step;
                        cnt_q   <= count;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        bw_q    <= 1'b1;
                        addr_q  <= A_ANGLE;
                        wdata_q <= wr_word;
`ifdef CORDIC_QUAD_FOLD_EN
                        fold_q  <= wr_fold;
`endif
                        state_q <= S_WRITE;
                    end else if (start) begin
                        done_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    bw_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    wait_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.done) begin
                        br_q    <= 1'b1;
                        addr_q  <= A_COS;
                        state_q <= S_RD_COS;
                    end else if (wait_d == WW'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_RD_COS: begin
                    cos_q   <= bus.rdata[15:0];
                    addr_q  <= A_SIN;
                    state_q <= S_RD_SIN;
                end
                S_RD_SIN: begin
                    sin_q   <= bus.rdata[15:0];
                    br_q    <= 1'b0;
                    addr_q  <= '0;
                    state_q <= S_PUSH;
                end
                S_PUSH: begin
                    // A full FIFO holds the point here; nothing advances
                    if (!full) begin
                        angle_q <= angle_d;
                        idx_q   <= idx_d;
                        if (idx_q == cnt_q - CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            bw_q    <= 1'b1;
                            addr_q  <= A_ANGLE;
                            wdata_q <= wr_word;
`ifdef CORDIC_QUAD_FOLD_EN
                            fold_q  <= wr_fold;
`endif
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign sweep_done    = done_q;
    assign err_timeout   = err_q;
    assign bus.bus_write = bw_q;
    assign bus.bus_read  = br_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.res_valid = !empty;
    assign bus.res_cos   = empty ? 16'h0 : head[EW-1 -: 16];
    assign bus.res_sin   = empty ? 16'h0 : head[CNT_W+15 -: 16];
    assign bus.res_idx   = empty ? '0 : head[CNT_W-1:0];
endmodule

// File: tb/tb_cordic_sweep_master.sv
// Self-checking bench: CORDIC responder model, result scoreboard,
// table of sweeps plus timeout, backpressure and reset sequences.
module tb_cordic_sweep_master;
    localparam int FD = 4;
    localparam int TO = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   angle_start, angle_step;
    logic [CW-1:0] count;
    logic          busy, sweep_done, err_timeout;

    cordic_sweep_master_if #(.CNT_W(CW)) bus ();

    cordic_sweep_master #(
        .FIFO_DEPTH(FD), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .angle_start(angle_start), .angle_step(angle_step),
        .count(count), .busy(busy), .sweep_done(sweep_done),
        .err_timeout(err_timeout), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   c;
        logic [15:0]   s;
        logic [CW-1:0] i;
    } ent_t;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] step;
        int          cnt;
        int          lat;
        logic [15:0] cv;
        logic [15:0] sv;
        int          exp_gap;
        logic [31:0] exp_last;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   strobes = 0;
    int   sd_cnt = 0;
    int   bus_viol = 0;
    int   pend = -1;
    int   lat = 17;
    bit   done_en = 1'b1;
    logic [15:0] cos_val = 16'h1234;
    logic [15:0] sin_val = 16'hFEDC;
    ent_t sb[$];
    int   wr_cyc[$];
    logic [31:0] wr_dat[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_wr(input logic [31:0] a);
`ifdef CORDIC_QUAD_FOLD_EN
        if (a[31:30] == 2'b01 || a[31:30] == 2'b10) return a ^ 32'h8000_0000;
`endif
        return a;
    endfunction

    function automatic logic [15:0] m_val(input logic [15:0] v,
                                          input logic [31:0] a);
`ifdef CORDIC_QUAD_FOLD_EN
        if (a[31:30] == 2'b01 || a[31:30] == 2'b10) begin
            if (v == 16'h8000) return 16'h7FFF;
            return 16'(0 - int'($signed(v)));
        end
`endif
        return v;
    endfunction

    // CORDIC peripheral model
    assign bus.rdata = (bus.addr == 6'h08) ? {16'hA5A5, cos_val} :
                       (bus.addr == 6'h0C) ? {16'h5A5A, sin_val} : 32'h0;
    assign bus.done  = (pend == 0);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.bus_write && done_en) pend = lat;
        else if (pend >= 0) pend = pend - 1;
    end

    always @(negedge clk) begin
        ent_t got, e;
        if (bus.bus_write) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(bus.wdata);
        end
        if (bus.bus_write || bus.bus_read) strobes++;
        if (!bus.bus_write && !bus.bus_read &&
            (bus.addr != 6'h0 || bus.wdata != 32'h0)) bus_viol++;
        if (sweep_done) sd_cnt++;
        if (bus.res_valid && bus.res_ready) begin
            got = '{bus.res_cos, bus.res_sin, bus.res_idx};
            if (sb.size() == 0) begin
                check("sb_unexpected_pop", 64'(got), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                check("sb_entry", 64'(got), 64'(e));
            end
        end
    end

    task automatic pulse_start(input logic [31:0] a0, input logic [31:0] st,
                               input int n);
        @(posedge clk); #1;
        angle_start = a0;
        angle_step  = st;
        count       = CW'(n);
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic expect_sweep(input logic [31:0] a0, input logic [31:0] st,
                                input int n, input logic [15:0] cv,
                                input logic [15:0] sv);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = a0 + 32'(i) * st;
            sb.push_back('{m_val(cv, a), m_val(sv, a), CW'(i)});
        end
    endtask

    task automatic wait_sd(input int budget, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (sweep_done) ok = 1'b1;
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int k = 0; k < budget && wr_cyc.size() < n; k++) @(negedge clk);
        check("wr_reached", 64'(wr_cyc.size()), 64'(n));
    endtask

    vec_t vt[4];

    initial begin
        int s0, sd0, t0;
        logic bsy;

        vt[0] = '{32'h0, 32'h1000_0000, 3, 17, 16'h1234, 16'hFEDC,
                  21, 32'h2000_0000};
        vt[1] = '{32'hF000_0000, 32'h0800_0000, 4, 5, 16'h7FFF, 16'h8000,
                  9, 32'h0800_0000};
        vt[2] = '{32'hC000_0000, 32'h1000_0000, 2, 40, 16'h0001, 16'hFFFF,
                  44, 32'hD000_0000};
        vt[3] = '{32'h1234_5678, 32'h4000_0000, 1, 17, 16'h0ABC, 16'hF123,
                  21, 32'h1234_5678};

        rst = 1'b1;
        start = 1'b0;
        angle_start = '0;
        angle_step = '0;
        count = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sd", 64'(sweep_done), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_bw", 64'(bus.bus_write), 64'd0);
        check("rst_br", 64'(bus.bus_read), 64'd0);
        check("rst_addr", 64'(bus.addr), 64'd0);
        check("rst_valid", 64'(bus.res_valid), 64'd0);

        for (int v = 0; v < 4; v++) begin
            lat = vt[v].lat;
            cos_val = vt[v].cv;
            sin_val = vt[v].sv;
            wr_cyc.delete();
            wr_dat.delete();
            expect_sweep(vt[v].a0, vt[v].step, vt[v].cnt, vt[v].cv, vt[v].sv);
            pulse_start(vt[v].a0, vt[v].step, vt[v].cnt);
            wait_sd(vt[v].cnt * (vt[v].lat + 4) + 20, "vec_sweep_done");
            @(negedge clk);
            check("vec_busy_end", 64'(busy), 64'd0);
            check("vec_err", 64'(err_timeout), 64'd0);
            drain("vec_drain");
            check("vec_nwr", 64'(wr_dat.size()), 64'(vt[v].cnt));
            for (int i = 0; i < wr_dat.size(); i++) begin
                check("vec_wdata", 64'(wr_dat[i]),
                      64'(m_wr(vt[v].a0 + 32'(i) * vt[v].step)));
                if (i > 0)
                    check("vec_gap", 64'(wr_cyc[i] - wr_cyc[i-1]),
                          64'(vt[v].exp_gap));
            end
            if (wr_dat.size() > 0)
                check("vec_last", 64'(wr_dat[wr_dat.size()-1]),
                      64'(m_wr(vt[v].exp_last)));
        end
        lat = 17;

        // count = 0: immediate done, no traffic
        wr_cyc.delete();
        wr_dat.delete();
        @(posedge clk); #1;
        count = '0;
        start = 1'b1;
        @(negedge clk);
        check("zero_sd_early", 64'(sweep_done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_sd", 64'(sweep_done), 64'd1);
        bsy = busy;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            bsy = bsy | busy;
        end
        check("zero_busy", 64'(bsy), 64'd0);
        check("zero_nwr", 64'(wr_cyc.size()), 64'd0);

        // timeout
        done_en = 1'b0;
        wr_cyc.delete();
        wr_dat.delete();
        sd0 = sd_cnt;
        pulse_start(32'h0, 32'h1000_0000, 2);
        wait_writes(1, 10);
        t0 = (wr_cyc.size() > 0) ? wr_cyc[0] : cyc;
        for (int k = 0; k < 200 && cyc < t0 + TO; k++) @(negedge clk);
        check("to_err_before", 64'(err_timeout), 64'd0);
        check("to_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        check("to_err", 64'(err_timeout), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("to_no_sd", 64'(sd_cnt - sd0), 64'd0);
        check("to_sticky", 64'(err_timeout), 64'd1);
        done_en = 1'b1;
        expect_sweep(32'h0800_0000, 32'h0, 1, cos_val, sin_val);
        pulse_start(32'h0800_0000, 32'h0, 1);
        @(negedge clk);
        check("to_err_clr", 64'(err_timeout), 64'd0);
        wait_sd(60, "to_restart_done");
        drain("to_drain");

        // backpressure with a full FIFO
        bus.res_ready = 1'b0;
        wr_cyc.delete();
        wr_dat.delete();
        expect_sweep(32'h0100_0000, 32'h0100_0000, 6, cos_val, sin_val);
        pulse_start(32'h0100_0000, 32'h0100_0000, 6);
        wait_writes(5, 300);
        repeat (30) @(negedge clk);
        s0 = strobes;
        repeat (30) @(negedge clk);
        check("bp_no_strobe", 64'(strobes - s0), 64'd0);
        check("bp_nwr", 64'(wr_cyc.size()), 64'd5);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_valid", 64'(bus.res_valid), 64'd1);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_sd(200, "bp_sweep_done");
        drain("bp_drain");
        check("bp_nwr_end", 64'(wr_dat.size()), 64'd6);
        if (wr_dat.size() == 6)
            check("bp_angle_hold", 64'(wr_dat[5]), 64'(m_wr(32'h0600_0000)));

        // reset while waiting on point 1
        bus.res_ready = 1'b0;
        wr_cyc.delete();
        wr_dat.delete();
        pulse_start(32'h0, 32'h1000_0000, 3);
        wait_writes(2, 100);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_sd", 64'(sweep_done), 64'd0);
        check("mr_bus", 64'({bus.bus_write, bus.bus_read, bus.addr}), 64'd0);
        check("mr_wdata", 64'(bus.wdata), 64'd0);
        check("mr_valid", 64'(bus.res_valid), 64'd0);
        check("mr_head", 64'({bus.res_cos, bus.res_sin, bus.res_idx}), 64'd0);
        bus.res_ready = 1'b1;
        s0 = strobes;
        bsy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bsy = bsy | busy | bus.res_valid;
        end
        check("mr_late_done", 64'(strobes - s0), 64'd0);
        check("mr_idle", 64'(bsy), 64'd0);

`ifdef CORDIC_QUAD_FOLD_EN
        cos_val = 16'd100;
        sin_val = 16'h8000;
        wr_cyc.delete();
        wr_dat.delete();
        sb.push_back('{16'hFF9C, 16'h7FFF, CW'(0)});
        pulse_start(32'h6000_0000, 32'h0, 1);
        wait_sd(60, "fold_done");
        drain("fold_drain");
        if (wr_dat.size() > 0)
            check("fold_wdata", 64'(wr_dat[0]), 64'hE000_0000);
        else
            check("fold_nwr", 64'(wr_dat.size()), 64'd1);
`endif

        check("bus_idle_zero", 64'(bus_viol), 64'd0);
        check("sb_final", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
